// File: rtl/bus_decoder.sv
// Table-driven, registered memory-map decoder: CPU data port to NSLV slave regions.
// Latency: strobe 1 cycle after request, m_ready 1 cycle after slave ready; errors answer in 1 cycle.
// Backpressure: m_busy stalls the master; slave wait held off by s_busy/s_ready, bounded by TIMEOUT.
module bus_decoder #(
    parameter int                   NSLV         = 3,
    parameter int                   AW           = 16,
    parameter int                   DW           = 16,
    parameter logic [NSLV*AW-1:0]   REGION_BASE  = {16'h4C00, 16'h1000, 16'h0000},
    parameter logic [NSLV*AW-1:0]   REGION_LIMIT = {16'hFFFF, 16'h4BFF, 16'h0000},
    parameter logic [NSLV-1:0]      RO_MASK      = 3'b001,
    parameter int                   TIMEOUT      = 255,
    parameter logic [DW-1:0]        ERR_DATA     = 16'hFFFF
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    input  logic [AW-1:0]        m_addr,
    input  logic [DW-1:0]        m_wdata,
    input  logic                 m_read,
    input  logic                 m_write,
    output logic [DW-1:0]        m_rdata,
    output logic                 m_busy,
    output logic                 m_ready,
    output logic                 m_err,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    output logic [NSLV-1:0]      s_read,
    output logic [NSLV-1:0]      s_write,
    input  logic [NSLV*DW-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_busy,
    input  logic [NSLV-1:0]      s_ready,
    output logic                 err_flag,
    output logic [1:0]           err_code,
    output logic [AW-1:0]        err_addr,
    input  logic                 err_clr
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] CODE_UNMAPPED = 2'd1;
    localparam logic [1:0] CODE_RO_WRITE = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            op_wr_q, op_wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   m_rdata_q, m_rdata_d;
    logic            err_flag_q, err_flag_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [AW-1:0]   err_addr_q, err_addr_d;

    logic            hit_c;
    logic [SW-1:0]   sel_c;
    logic            ro_c;
    logic [AW-1:0]   rel_c;
    logic [AW:0]     lo_c;
    logic [AW-1:0]   span_c;

    logic            sel_rdy_c;
    logic            sel_busy_c;
    logic [DW-1:0]   sel_rdata_c;

    logic            req_c;
    logic [1:0]      new_code_c;
    logic [AW-1:0]   new_addr_c;

    // Descending scan so the lowest matching index is the last one written.
    // The offset borrow gives addr >= base; the span test gives addr <= limit.
    always_comb begin
        hit_c  = 1'b0;
        sel_c  = '0;
        ro_c   = 1'b0;
        rel_c  = '0;
        lo_c   = '0;
        span_c = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            lo_c   = {1'b0, m_addr} - {1'b0, REGION_BASE[i*AW +: AW]};
            span_c = REGION_LIMIT[i*AW +: AW] - REGION_BASE[i*AW +: AW];
            if (!lo_c[AW] && (lo_c[AW-1:0] <= span_c)) begin
                hit_c = 1'b1;
                sel_c = SW'(i);
                ro_c  = RO_MASK[i];
                rel_c = lo_c[AW-1:0];
            end
        end
    end

    // Selected-slave return path and one-hot strobes, driven only during ISSUE.
    always_comb begin
        sel_rdy_c   = 1'b0;
        sel_busy_c  = 1'b0;
        sel_rdata_c = '0;
        s_read      = '0;
        s_write     = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SW'(i)) begin
                sel_rdy_c   = s_ready[i];
                sel_busy_c  = s_busy[i];
                sel_rdata_c = s_rdata[i*DW +: DW];
                if (state_q == ST_ISSUE) begin
                    s_read[i]  = ~op_wr_q;
                    s_write[i] = op_wr_q;
                end
            end
        end
    end

    assign req_c = m_read | m_write;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        sel_d      = sel_q;
        op_wr_d    = op_wr_q;
        cnt_d      = cnt_q;
        m_rdata_d  = m_rdata_q;
        err_flag_d = err_flag_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        new_code_c = CODE_UNMAPPED;
        new_addr_c = m_addr;
        m_busy     = 1'b0;
        m_ready    = 1'b0;
        m_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                m_busy = req_c;
                if (req_c) begin
                    addr_d    = m_addr;
                    s_addr_d  = rel_c;
                    s_wdata_d = m_wdata;
                    sel_d     = sel_c;
                    op_wr_d   = m_write;
                    if (!hit_c) begin
                        state_d    = ST_ERR;
                        new_code_c = CODE_UNMAPPED;
                    end else if (m_write && ro_c) begin
                        state_d    = ST_ERR;
                        new_code_c = CODE_RO_WRITE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                m_busy  = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                m_busy = 1'b1;
                if (sel_rdy_c && !sel_busy_c) begin
                    if (!op_wr_q) begin
                        m_rdata_d = sel_rdata_c;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d    = ST_ERR;
                    new_code_c = CODE_TIMEOUT;
                    new_addr_c = addr_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                m_ready = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                m_ready = 1'b1;
                m_err   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_ERR) begin
            m_rdata_d = ERR_DATA;
        end

        // A clear coinciding with a new error drops that error; the next one is logged.
        if (err_clr) begin
            err_flag_d = 1'b0;
            err_code_d = '0;
            err_addr_d = '0;
        end else if (state_d == ST_ERR && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_code_d = new_code_c;
            err_addr_d = new_addr_c;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            sel_q      <= '0;
            op_wr_q    <= 1'b0;
            cnt_q      <= '0;
            m_rdata_q  <= '0;
            err_flag_q <= 1'b0;
            err_code_q <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            sel_q      <= sel_d;
            op_wr_q    <= op_wr_d;
            cnt_q      <= cnt_d;
            m_rdata_q  <= m_rdata_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_rdata  = m_rdata_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign err_flag = err_flag_q;
    assign err_code = err_code_q;
    assign err_addr = err_addr_q;

endmodule
